bram_arbiter: RTL and testbench

//   Shares the single block_ram Wishbone-style slave port between two hart masters:
//   M0 = instruction fetch, M1 = load/store.
//   - Round-robin grant; one transaction in flight at a time.
//   - Routes ack/data back to the grant owner only.
//   - Releases the bus on an ack timeout so a dead slave cannot hang the hart.
//   - Sits between hart0 and bram in the testbenches and in the SoC top.

---
 rtl/bram_arbiter_pkg.sv | 13 +
 rtl/bram_arbiter.sv | 151 +++++++++++++++
 tb/tb_bram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-master block RAM arbiter: FSM states and master indices.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic M_FETCH = 1'b0;
    localparam logic M_LSU   = 1'b1;

endpackage

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style block RAM port between the fetch
// (M0) and load/store (M1) masters, one transaction in flight, with an ack timeout.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SELW    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_m0_stb,
    input  logic            i_m0_we,
    input  logic [SELW-1:0] i_m0_sel,
    input  logic [XLEN-1:0] i_m0_addr,
    input  logic [XLEN-1:0] i_m0_data,
    output logic            o_m0_stall,
    output logic            o_m0_ack,
    output logic            o_m0_err,
    output logic [XLEN-1:0] o_m0_data,
    input  logic            i_m1_stb,
    input  logic            i_m1_we,
    input  logic [SELW-1:0] i_m1_sel,
    input  logic [XLEN-1:0] i_m1_addr,
    input  logic [XLEN-1:0] i_m1_data,
    output logic            o_m1_stall,
    output logic            o_m1_ack,
    output logic            o_m1_err,
    output logic [XLEN-1:0] o_m1_data,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [SELW-1:0] o_s_sel,
    output logic [XLEN-1:0] o_s_addr,
    output logic [XLEN-1:0] o_s_data,
    input  logic [XLEN-1:0] i_s_data,
    input  logic            i_s_stall,
    input  logic            i_s_ack,
    output state_t          o_dbg_state
);

    // Handshake: a request transfers in the cycle where stb is high and stall is low;
    // the master holds stb and its fields stable until then. Completion is a single
    // cycle pulse of ack (data valid) or err, delivered only to the grant owner.

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            rr_last_q, rr_last_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic            own_stb;
    logic            own_we;
    logic [SELW-1:0] own_sel;
    logic [XLEN-1:0] own_addr;
    logic [XLEN-1:0] own_data;
    logic            done_ack;
    logic            done_err;

    always_comb begin
        own_stb  = i_m0_stb;
        own_we   = i_m0_we;
        own_sel  = i_m0_sel;
        own_addr = i_m0_addr;
        own_data = i_m0_data;
        if (owner_q == M_LSU) begin
            own_stb  = i_m1_stb;
            own_we   = i_m1_we;
            own_sel  = i_m1_sel;
            own_addr = i_m1_addr;
            own_data = i_m1_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        tmo_cnt_d = tmo_cnt_q;
        o_s_stb   = 1'b0;
        o_s_we    = 1'b0;
        o_s_sel   = '0;
        o_s_addr  = '0;
        o_s_data  = '0;
        done_ack  = 1'b0;
        done_err  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the master that did not complete last wins.
                if (i_m0_stb || i_m1_stb) begin
                    owner_d = (i_m0_stb && i_m1_stb) ? ~rr_last_q : i_m1_stb;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_s_stb  = own_stb;
                o_s_we   = own_we;
                o_s_sel  = own_sel;
                o_s_addr = own_addr;
                o_s_data = own_data;
                if (!own_stb) begin
                    state_d = IDLE;
                end else if (!i_s_stall) begin
                    state_d   = WAIT;
                    tmo_cnt_d = '0;
                end
            end
            WAIT: begin
                if (i_s_ack) begin
                    done_ack  = 1'b1;
                    rr_last_d = owner_q;
                    state_d   = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    done_err  = 1'b1;
                    rr_last_d = owner_q;
                    state_d   = IDLE;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            owner_q   <= M_FETCH;
            rr_last_q <= M_LSU;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign o_m0_stall  = !(state_q == ISSUE && owner_q == M_FETCH && !i_s_stall);
    assign o_m1_stall  = !(state_q == ISSUE && owner_q == M_LSU && !i_s_stall);
    assign o_m0_ack    = done_ack && (owner_q == M_FETCH);
    assign o_m1_ack    = done_ack && (owner_q == M_LSU);
    assign o_m0_err    = done_err && (owner_q == M_FETCH);
    assign o_m1_err    = done_err && (owner_q == M_LSU);
    assign o_m0_data   = i_s_data;
    assign o_m1_data   = i_s_data;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic, with responses
// predicted from a transaction-level model and checked by an independent monitor.
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    localparam int XLEN    = 32;
    localparam int SELW    = 3;
    localparam int TIMEOUT = 15;
    // entry: {master, is_err, is_read, data[31:0], cycle[31:0]}
    localparam int EW = 3 + XLEN + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            i_m0_stb, i_m0_we, i_m1_stb, i_m1_we;
    logic [SELW-1:0] i_m0_sel, i_m1_sel;
    logic [XLEN-1:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
    logic            o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err;
    logic [XLEN-1:0] o_m0_data, o_m1_data;
    logic            o_s_stb, o_s_we;
    logic [SELW-1:0] o_s_sel;
    logic [XLEN-1:0] o_s_addr, o_s_data, i_s_data;
    logic            i_s_stall, i_s_ack;
    state_t          o_dbg_state;

    bram_arbiter #(.XLEN(XLEN), .SELW(SELW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we), .i_m0_sel(i_m0_sel),
        .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data),
        .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .o_m0_data(o_m0_data),
        .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we), .i_m1_sel(i_m1_sel),
        .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data),
        .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_m1_data(o_m1_data),
        .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_data(i_s_data), .i_s_stall(i_s_stall), .i_s_ack(i_s_ack),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- bench state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];
    int grant_log[$];

    bit              m_pend[2];
    bit              m_busy[2];
    bit              m_auto[2];
    int              m_start[2];
    logic            m_we[2];
    logic [SELW-1:0] m_sel[2];
    logic [XLEN-1:0] m_addr[2];
    logic [XLEN-1:0] m_data[2];
    bit              req_always = 1'b0;

    logic [XLEN-1:0] mem[32];
    logic [XLEN-1:0] ref_mem[32];
    logic [XLEN-1:0] s_rdata;
    int  ack_cnt = 0;
    int  force_stall = 0;
    int  fixed_delay = 1;
    bit  noack_next = 1'b0;
    bit  inject_ack = 1'b0;
    bit  rand_mode = 1'b0;
    bit  s_stb_prev = 1'b0;
    int  issue_start = 0;
    int  accept_cyc = 0;
    int  last_done = 1;
    int  last_resp_cyc = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_req(input int m, input logic we, input logic [XLEN-1:0] addr);
        m_pend[m] = 1'b1;
        m_we[m]   = we;
        m_sel[m]  = SELW'($urandom_range(0, 7));
        m_addr[m] = addr;
        m_data[m] = $urandom;
        m_start[m] = cyc + 1;
    endtask

    // Slave accepted a request this cycle: predict the winner from the round-robin
    // rule and queue the response the owner should eventually see.
    task automatic accept();
        bit p0, p1, noack;
        int x, d, r;
        logic [4:0] idx;
        logic [XLEN-1:0] exp_data;
        p0 = m_pend[0] && (m_start[0] < issue_start);
        p1 = m_pend[1] && (m_start[1] < issue_start);
        if (!p0 && !p1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_issue: slave accepted 0x%0h with no pending master", o_s_addr);
            return;
        end
        x = (p0 && p1) ? ((last_done == 0) ? 1 : 0) : (p1 ? 1 : 0);
        check("grant_stalls", {78'd0, o_m0_stall, o_m1_stall}, (x == 1) ? 80'b10 : 80'b01);
        check("req_fields", {11'd0, o_s_we, o_s_sel, o_s_addr, o_s_data},
              {11'd0, m_we[x], m_sel[x], m_addr[x], m_data[x]});
        noack = 1'b0;
        d = fixed_delay;
        if (noack_next) begin
            noack = 1'b1;
            noack_next = 1'b0;
        end else if (rand_mode) begin
            r = $urandom_range(0, 31);
            if (r == 0) noack = 1'b1;
            else if (r == 1) d = TIMEOUT;
            else d = 1 + (r % 3);
        end
        idx = o_s_addr[6:2];
        s_rdata = mem[idx];
        if (o_s_we) mem[idx] = o_s_data;
        exp_data = ref_mem[m_addr[x][6:2]];
        if (m_we[x]) ref_mem[m_addr[x][6:2]] = m_data[x];
        exp_q.push_back({x[0], noack, !m_we[x], exp_data, 32'(cyc + (noack ? TIMEOUT : d))});
        ack_cnt = noack ? 0 : d;
        m_pend[x] = 1'b0;
        m_busy[x] = 1'b1;
        grant_log.push_back(x);
        accept_cyc = cyc;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (m_auto[m] && !m_pend[m] && !m_busy[m] && rst_n &&
                (req_always || $urandom_range(0, 2) == 0)) begin
                new_req(m, 1'($urandom_range(0, 1)), {25'd0, 5'($urandom_range(0, 31)), 2'b00});
                m_start[m] = cyc;
            end
        end
        i_m0_stb = m_pend[0]; i_m0_we = m_we[0]; i_m0_sel = m_sel[0];
        i_m0_addr = m_addr[0]; i_m0_data = m_data[0];
        i_m1_stb = m_pend[1]; i_m1_we = m_we[1]; i_m1_sel = m_sel[1];
        i_m1_addr = m_addr[1]; i_m1_data = m_data[1];
        if (force_stall > 0) i_s_stall = 1'b1;
        else if (rand_mode) i_s_stall = ($urandom_range(0, 3) == 0);
        else i_s_stall = 1'b0;
        i_s_ack = 1'b0;
        i_s_data = $urandom;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                i_s_ack = 1'b1;
                i_s_data = s_rdata;
            end
        end
        if (inject_ack) begin
            i_s_ack = 1'b1;
            inject_ack = 1'b0;
        end
        @(negedge clk);
        if (o_s_stb && !s_stb_prev) issue_start = cyc;
        s_stb_prev = o_s_stb;
        if (o_s_stb && i_s_stall && force_stall > 0) force_stall--;
        if (o_s_stb && !i_s_stall && rst_n) accept();
    endtask

    task automatic run_until_idle(input string name, input int bound);
        int k = 0;
        while ((m_pend[0] || m_pend[1] || m_busy[0] || m_busy[1]) && k < bound) begin
            step();
            k++;
        end
        if (m_pend[0] || m_pend[1] || m_busy[0] || m_busy[1]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: masters still busy after %0d cycles, required idle", name, bound);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int m = 0; m < 2; m++) begin
                logic a, e;
                logic [XLEN-1:0] rd;
                logic [EW-1:0] ent;
                a  = (m == 0) ? o_m0_ack : o_m1_ack;
                e  = (m == 0) ? o_m0_err : o_m1_err;
                rd = (m == 0) ? o_m0_data : o_m1_data;
                if (a || e) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: m%0d ack=%0b err=%0b, expected none (cycle %0d)",
                                 m, a, e, cyc);
                    end else begin
                        ent = exp_q.pop_front();
                        check("resp_master", 80'(m), {79'd0, ent[EW-1]});
                        check("resp_kind", {78'd0, a, e}, {78'd0, !ent[EW-2], ent[EW-2]});
                        check("resp_cycle", 80'(cyc), {48'd0, ent[31:0]});
                        if (a && ent[EW-3]) check("resp_data", {48'd0, rd}, {48'd0, ent[63:32]});
                        m_busy[ent[EW-1]] = 1'b0;
                        last_done = int'(ent[EW-1]);
                        last_resp_cyc = cyc;
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int k;
        int s;
        rst_n = 1'b0;
        i_m0_stb = 0; i_m0_we = 0; i_m0_sel = 0; i_m0_addr = 0; i_m0_data = 0;
        i_m1_stb = 0; i_m1_we = 0; i_m1_sel = 0; i_m1_addr = 0; i_m1_data = 0;
        i_s_data = 0; i_s_stall = 0; i_s_ack = 0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_busy[i] = 0; m_auto[i] = 0; m_start[i] = 0;
            m_we[i] = 0; m_sel[i] = 0; m_addr[i] = 0; m_data[i] = 0;
        end
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset held with both strobes up.
        new_req(0, 1'b0, 32'h4);
        new_req(1, 1'b1, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_s_stb", {79'd0, o_s_stb}, 80'd0);
            check("rst_resp", {76'd0, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, 80'd0);
            check("rst_stalls", {78'd0, o_m0_stall, o_m1_stall}, 80'b11);
            check("rst_state", {78'd0, o_dbg_state}, {78'd0, IDLE});
        end
        m_pend[0] = 0;
        m_pend[1] = 0;
        step();
        rst_n = 1'b1;
        step();

        // Single M1 read from 0x40.
        new_req(1, 1'b0, 32'h40);
        s = m_start[1];
        run_until_idle("t2_drain", 20);
        check("t2_latency", 80'(last_resp_cyc - s), 80'd2);

        // Both masters contend: grants must alternate starting with M0.
        grant_log.delete();
        req_always = 1'b1;
        m_auto[0] = 1'b1;
        m_auto[1] = 1'b1;
        k = 0;
        while (grant_log.size() < 4 && k < 40) begin
            step();
            k++;
        end
        m_auto[0] = 1'b0;
        m_auto[1] = 1'b0;
        req_always = 1'b0;
        run_until_idle("t3_drain", 40);
        for (int i = 0; i < 4; i++) begin
            if (grant_log.size() > i) check("t3_grant_order", 80'(grant_log[i]), 80'(i % 2));
        end

        // Slave stalls the issued request for five cycles.
        force_stall = 5;
        new_req(0, 1'b1, 32'h10);
        k = 0;
        while (m_pend[0] && k < 20) begin
            step();
            k++;
            if (o_s_stb && i_s_stall) begin
                check("t4_stall_held", {79'd0, o_m0_stall}, 80'd1);
                check("t4_state_issue", {78'd0, o_dbg_state}, {78'd0, ISSUE});
            end
        end
        check("t4_accept_cycle", 80'(accept_cyc - issue_start), 80'd5);
        run_until_idle("t4_drain", 20);

        // Slave never acks: M0 gets err, then M1 wins the next tie.
        noack_next = 1'b1;
        new_req(0, 1'b0, 32'h20);
        run_until_idle("t5_drain", 40);
        check("t5_err_delay", 80'(last_resp_cyc - accept_cyc), 80'(TIMEOUT));
        grant_log.delete();
        new_req(0, 1'b0, 32'h24);
        new_req(1, 1'b0, 32'h28);
        run_until_idle("t5_next_drain", 40);
        if (grant_log.size() > 0) check("t5_next_grant", 80'(grant_log[0]), 80'd1);

        // Reset during WAIT, then a stale slave ack right after release.
        noack_next = 1'b1;
        new_req(0, 1'b0, 32'h30);
        k = 0;
        while (o_dbg_state != WAIT && k < 10) begin
            step();
            k++;
        end
        step();
        rst_n = 1'b0;
        exp_q.delete();
        m_busy[0] = 0; m_busy[1] = 0; m_pend[0] = 0; m_pend[1] = 0;
        ack_cnt = 0;
        last_done = 1;
        step();
        step();
        rst_n = 1'b1;
        inject_ack = 1'b1;
        step();
        check("t6_ack_dropped", {76'd0, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, 80'd0);
        check("t6_state", {78'd0, o_dbg_state}, {78'd0, IDLE});
        step();
        check("t6_state_after", {78'd0, o_dbg_state}, {78'd0, IDLE});

        // Random traffic with random stalls, latencies and occasional dead slave.
        rand_mode = 1'b1;
        fixed_delay = 1;
        m_auto[0] = 1'b1;
        m_auto[1] = 1'b1;
        for (int i = 0; i < 1500; i++) step();
        m_auto[0] = 1'b0;
        m_auto[1] = 1'b0;
        run_until_idle("rand_drain", 200);
        check("exp_q_empty", 80'(exp_q.size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
